alu: RTL and testbench



---
 rtl/alu.sv | 106 ++++++++++
 tb/tb_alu.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered ALU for the execute stage.
// Two WIDTH-bit operands and a 4-bit operation select produce a WIDTH-bit
// result plus zero / negative / signed-overflow flags, one cycle after the
// inputs are sampled. sel=0 holds every output register.
// Optional feature macro: ALU_CARRY_EN adds the registered carry output c.
module alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             z,
  output logic             n,
  output logic             v,
`ifdef ALU_CARRY_EN
  output logic             c,
`endif
  output logic [WIDTH-1:0] out
);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_SHL   = 4'd3;
  localparam logic [3:0] OP_SHR   = 4'd4;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_PASSB = 4'd7;
  localparam logic [3:0] OP_PASSA = 4'd8;
  localparam logic [3:0] OP_VCC   = 4'd9;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  // One extra bit on top so the last bit shifted out of a lands at [WIDTH];
  // shift amounts beyond WIDTH push everything out and leave zeros.
  logic [WIDTH:0]   w_shl_ext;
  logic [WIDTH-1:0] w_res;
  logic             w_v;
  logic             w_c;

  assign w_sum     = a + b;
  assign w_diff    = a - b;
  assign w_shl_ext = {1'b0, a} << b;

  // Result, overflow and carry selection for the current operation.
  always_comb begin
    w_res = '0;
    w_v   = 1'b0;
    w_c   = 1'b0;
    case (sel)
      OP_ADD: begin
        w_res = w_sum;
        w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
        w_c   = (w_sum < a);
      end
      OP_SUB: begin
        w_res = w_diff;
        w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
        w_c   = (a >= b);
      end
      OP_SHL: begin
        w_res = w_shl_ext[WIDTH-1:0];
        w_c   = w_shl_ext[WIDTH];
      end
      OP_SHR:   w_res = a >> b;
      OP_AND:   w_res = a & b;
      OP_OR:    w_res = a | b;
      OP_PASSB: w_res = b;
      OP_PASSA: w_res = a;
      OP_VCC:   w_res = '1;
      default:  w_res = '0;
    endcase
  end

  logic w_upd;
  assign w_upd = (sel != OP_NOP);

  // Output registers; NOP leaves them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
      z   <= 1'b1;
      n   <= 1'b0;
      v   <= 1'b0;
    end else if (w_upd) begin
      out <= w_res;
      z   <= (w_res == '0);
      n   <= w_res[WIDTH-1];
      v   <= w_v;
    end
  end

`ifdef ALU_CARRY_EN
  // Carry register, held on NOP like the other outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     c <= 1'b0;
    else if (w_upd) c <= w_c;
  end
`else
  logic w_c_unused;
  assign w_c_unused = w_c;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu (WIDTH=8), directed steps plus a random tail.
module tb_alu;

  typedef struct packed {
    logic [7:0] out;
    logic       z;
    logic       n;
    logic       v;
    logic       c;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a, b;
  logic [3:0] sel;
  logic       z, n, v;
  logic [7:0] out;
`ifdef ALU_CARRY_EN
  logic       c;
`endif

  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t prev;

  alu #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .sel  (sel),
    .z    (z),
    .n    (n),
    .v    (v),
`ifdef ALU_CARRY_EN
    .c    (c),
`endif
    .out  (out)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(logic [7:0] o, logic zz, logic nn, logic vv, logic cc);
    exp_t e;
    e.out = o; e.z = zz; e.n = nn; e.v = vv; e.c = cc;
    return e;
  endfunction

  // Reference behaviour written with integer arithmetic.
  function automatic exp_t model(logic [7:0] ia, logic [7:0] ib, logic [3:0] isel, exp_t p);
    exp_t e;
    int ua, ub, sa, sb_, r;
    ua = int'(ia); ub = int'(ib);
    sa = $signed(ia); sb_ = $signed(ib);
    if (isel == 4'd0) return p;
    e = '0;
    case (isel)
      4'd1: begin
        r = ua + ub; e.out = r[7:0]; e.c = (r > 255);
        e.v = ((sa + sb_) > 127) || ((sa + sb_) < -128);
      end
      4'd2: begin
        r = ua - ub; e.out = r[7:0]; e.c = (ua >= ub);
        e.v = ((sa - sb_) > 127) || ((sa - sb_) < -128);
      end
      4'd3: begin
        e.out = (ub >= 8) ? 8'h00 : 8'((ua * (2 ** ub)) % 256);
        e.c   = (ub == 0 || ub > 8) ? 1'b0 : ia[8-ub];
      end
      4'd4: e.out = (ub >= 8) ? 8'h00 : 8'(ua / (2 ** ub));
      4'd5: e.out = ia & ib;
      4'd6: e.out = ia | ib;
      4'd7: e.out = ib;
      4'd8: e.out = ia;
      4'd9: e.out = 8'hFF;
      default: e.out = 8'h00;
    endcase
    e.z = (e.out == 8'h00);
    e.n = e.out[7];
    return e;
  endfunction

  task automatic cmp(input string tag, input string fld, input logic [7:0] got, input logic [7:0] want);
    n_chk++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s.%s: observed %h expected %h", tag, fld, got, want);
    end
  endtask

  task automatic check_now(input string tag, input exp_t e);
    cmp(tag, "out", out, e.out);
    cmp(tag, "z", {7'd0, z}, {7'd0, e.z});
    cmp(tag, "n", {7'd0, n}, {7'd0, e.n});
    cmp(tag, "v", {7'd0, v}, {7'd0, e.v});
`ifdef ALU_CARRY_EN
    cmp(tag, "c", {7'd0, c}, {7'd0, e.c});
`endif
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    n_chk++;
    assert (sb.size() > 0) else begin
      n_err++;
      $error("FAIL %s.queue: observed empty expected entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_now(tag, e);
    end
  endtask

  // Drive one operation on the falling edge, expect it after the next rising edge.
  task automatic step(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                      input logic [3:0] isel, input exp_t e);
    @(negedge clk);
    a = ia; b = ib; sel = isel;
    sb.push_back(e);
    prev = e;
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  exp_t rst_val;

  initial begin
    rst_val = mk(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0; a = 8'h11; b = 8'h22; sel = 4'd1;
    repeat (2) @(posedge clk);
    #1;
    check_now("reset_init", rst_val);
    @(negedge clk);
    rst_n = 1'b1;

    step("add_ovf", 8'h7F, 8'h05, 4'd1, mk(8'h84, 0, 1, 1, 0));
    step("nop1", 8'h01, 8'h01, 4'd0, prev);
    step("nop2", 8'hAA, 8'h55, 4'd0, prev);
    step("nop3", 8'h00, 8'h00, 4'd0, prev);

    // Asynchronous reset in the middle of the low phase, away from any edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("reset_async", rst_val);
    a = 8'h01; b = 8'h01; sel = 4'd1;
    @(posedge clk);
    #1;
    check_now("reset_hold", rst_val);
    @(negedge clk);
    rst_n = 1'b1;
    prev = rst_val;

    step("sub_eq",   8'hCC, 8'hCC, 4'd2, mk(8'h00, 1, 0, 0, 1));
    step("sub_pos",  8'd57, 8'd51, 4'd2, mk(8'h06, 0, 0, 0, 1));
    step("sub_neg",  8'd30, 8'd100, 4'd2, mk(8'hBA, 0, 1, 0, 0));
    step("sub_ovf",  8'h80, 8'h01, 4'd2, mk(8'h7F, 0, 0, 1, 1));
    step("add_wrap", 8'hFF, 8'h01, 4'd1, mk(8'h00, 1, 0, 0, 1));
    step("shl2",     8'hFF, 8'h02, 4'd3, mk(8'hFC, 0, 1, 0, 1));
    step("shr2",     8'hFF, 8'h02, 4'd4, mk(8'h3F, 0, 0, 0, 0));
    step("shl8",     8'hFF, 8'h08, 4'd3, mk(8'h00, 1, 0, 0, 1));
    step("shl9",     8'hFF, 8'h09, 4'd3, mk(8'h00, 1, 0, 0, 0));
    step("shl0",     8'h81, 8'h00, 4'd3, mk(8'h81, 0, 1, 0, 0));
    step("shr8",     8'hFF, 8'h08, 4'd4, mk(8'h00, 1, 0, 0, 0));
    step("and",      8'hFF, 8'h02, 4'd5, mk(8'h02, 0, 0, 0, 0));
    step("or",       8'hFF, 8'h02, 4'd6, mk(8'hFF, 0, 1, 0, 0));
    step("passb",    8'hFF, 8'h02, 4'd7, mk(8'h02, 0, 0, 0, 0));
    step("passa",    8'hFF, 8'h02, 4'd8, mk(8'hFF, 0, 1, 0, 0));
    step("vcc",      8'hFF, 8'h02, 4'd9, mk(8'hFF, 0, 1, 0, 0));
    step("sel12",    8'hFF, 8'h02, 4'd12, mk(8'h00, 1, 0, 0, 0));
    step("sel15",    8'h7F, 8'h7F, 4'd15, mk(8'h00, 1, 0, 0, 0));

    for (int i = 0; i < 60; i++) begin
      logic [7:0] ra, rb;
      logic [3:0] rs;
      ra = 8'($urandom_range(0, 255));
      rb = (i % 3 == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom_range(0, 255));
      rs = 4'($urandom_range(0, 15));
      step("rand", ra, rb, rs, model(ra, rb, rs, prev));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
